// File: rtl/fb_scanout_rd_pkg.sv
// Shared definitions for the frame-buffer scan-out read path: FSM states,
// default widths and the read/write enable polarity helper.
package fb_scanout_rd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } fb_state_e;

   localparam int FB_DEF_DATA_WIDTH = 16;
   localparam int FB_DEF_ADDR_WIDTH = 3;
   localparam int FB_TAG_BITS       = 2;

   // Maps a logical enable onto the pin level for either polarity.
   function automatic logic fb_en_level(input logic active, input logic act_low);
      return active ^ act_low;
   endfunction

endpackage

// File: rtl/fb_sync_fifo.sv
// Synchronous show-ahead FIFO with occupancy count. The head entry is
// visible on rd_data whenever valid is high; pushing into a full FIFO is
// allowed only together with a pop.
module fb_sync_fifo #(
   parameter int WIDTH = 18,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       valid,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             full;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign valid   = (count != '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop & valid;
   assign do_push = push & (~full | do_pop);
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

   // The upstream credit scheme must never present a word to a full FIFO.
   a_no_overflow : assert property (@(posedge clk) disable iff (reset)
      !(push && full && !pop));

endmodule

// File: rtl/fb_scanout_rd.sv
// Frame-buffer scan-out read controller: issues sequential memory reads under
// FIFO credit and streams the words out with sof/eof. Optional macro
// FB_SCANOUT_CONT_EN selects free-running refresh instead of single-shot.
module fb_scanout_rd
   import fb_scanout_rd_pkg::*;
#(
   parameter int DATA_WIDTH    = FB_DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH    = FB_DEF_ADDR_WIDTH,
   parameter int FRAME_WORDS   = 2 ** ADDR_WIDTH,
   parameter int FIFO_DEPTH    = 4,
   parameter int RD_EN_ACT_LOW = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  mem_rd_en,
   output logic [ADDR_WIDTH-1:0] mem_rd_addr,
   input  logic [DATA_WIDTH-1:0] mem_rd_data,
   output logic [DATA_WIDTH-1:0] pix_data,
   output logic                  pix_valid,
   input  logic                  pix_ready,
   output logic                  pix_sof,
   output logic                  pix_eof
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int SW = $clog2(FIFO_DEPTH + 3);
   localparam int FW = DATA_WIDTH + FB_TAG_BITS;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_WORDS - 1);

   fb_state_e             state;
   fb_state_e             state_nxt;
   logic [ADDR_WIDTH-1:0] addr_cnt;
   logic [ADDR_WIDTH-1:0] addr_cnt_nxt;
   logic                  issue_p0;
   logic                  vld_p1;
   logic                  vld_p2;
   logic [ADDR_WIDTH-1:0] addr_p2;
   logic [FW-1:0]         fifo_wr_data;
   logic [FW-1:0]         fifo_rd_data;
   logic                  fifo_valid;
   logic [CW-1:0]         fifo_count;
   logic                  pop;
   logic                  credit_ok;
   logic                  last_addr;
   logic                  head_sof;
   logic                  head_eof;
   logic                  eof_pop;

   assign pop       = fifo_valid & pix_ready;
   assign head_sof  = fifo_rd_data[DATA_WIDTH+1];
   assign head_eof  = fifo_rd_data[DATA_WIDTH];
   assign eof_pop   = pop & head_eof;
   assign last_addr = (addr_cnt == LAST_ADDR);

   // Words in the FIFO plus reads on the memory port (address and data
   // phases) are all owed a FIFO slot; a pop this cycle frees one.
   assign credit_ok = (SW'(fifo_count) + SW'(vld_p1) + SW'(vld_p2))
                      < (SW'(FIFO_DEPTH) + SW'(pop));

   always_comb begin
      state_nxt    = state;
      issue_p0     = 1'b0;
      addr_cnt_nxt = addr_cnt;
      case (state)
         ST_IDLE: begin
            if (start) begin
               issue_p0  = 1'b1;
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (credit_ok) begin
               issue_p0 = 1'b1;
`ifdef FB_SCANOUT_CONT_EN
               state_nxt = ST_RUN;
`else
               if (last_addr) state_nxt = ST_DRAIN;
`endif
            end
         end
         ST_DRAIN: begin
            if (eof_pop) begin
               if (start) begin
                  issue_p0  = 1'b1;
                  state_nxt = ST_RUN;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (issue_p0) addr_cnt_nxt = last_addr ? '0 : addr_cnt + ADDR_WIDTH'(1);
   end

   // p0 -> p1: read request registered onto the memory port
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         addr_cnt    <= '0;
         vld_p1      <= 1'b0;
         vld_p2      <= 1'b0;
         mem_rd_en   <= fb_en_level(1'b0, RD_EN_ACT_LOW != 0);
         mem_rd_addr <= '0;
      end else begin
         state     <= state_nxt;
         addr_cnt  <= addr_cnt_nxt;
         vld_p1    <= issue_p0;
         vld_p2    <= vld_p1;
         mem_rd_en <= fb_en_level(issue_p0, RD_EN_ACT_LOW != 0);
         if (issue_p0) mem_rd_addr <= addr_cnt;
      end
   end

   // p1 -> p2: address follows the read into the data-return cycle
   always_ff @(posedge clk) begin
      addr_p2 <= mem_rd_addr;
   end

   assign fifo_wr_data = {addr_p2 == '0, addr_p2 == LAST_ADDR, mem_rd_data};

   fb_sync_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (vld_p2),
      .wr_data (fifo_wr_data),
      .pop     (pop),
      .rd_data (fifo_rd_data),
      .valid   (fifo_valid),
      .count   (fifo_count)
   );

   assign pix_valid = fifo_valid;
   assign pix_data  = fifo_valid ? fifo_rd_data[DATA_WIDTH-1:0] : '0;
   assign pix_sof   = fifo_valid & head_sof;
   assign pix_eof   = fifo_valid & head_eof;
   assign busy      = (state != ST_IDLE);
   assign done      = eof_pop;

endmodule
